mux4_rr_arbiter: RTL and testbench
==================================

MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, data word width of each requester and of the output.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately, independent of clk.
REQ-004 req  input  4  request lines, bit i = requester i has a word on data_i.
REQ-005 data0, data1, data2, data3  input  WIDTH each  requester words; feed the shared 32-bit 4-to-1 mux.
REQ-006 s1, s0  output  1 each  registered mux select lines; {s1,s0} = index of current grantee.
REQ-007 out_data  output  WIDTH  registered copy of selected word.
REQ-008 out_valid  output  1  out_data holds a granted, not yet accepted word.
REQ-009 out_ready  input  1  consumer accepts out_data when out_valid & out_ready at a rising edge.
REQ-010 ack  output  4  one-hot, one-cycle pulse to the requester whose word was accepted.
REQ-011 busy  output  1  high while state = HOLD.
REQ-012 xfer_count  output  16  count of accepted transfers, wraps 0xFFFF -> 0x0000.

Function
REQ-013 FSM SHALL have exactly two states: IDLE (no word held) and HOLD (word held, out_valid=1).
REQ-014 Round-robin pointer ptr[1:0] SHALL hold the index of the last accepted requester; search order is ptr+1, ptr+2, ptr+3, ptr (mod 4).
REQ-015 IDLE, any req bit set at edge: winner = first set bit in search order; {s1,s0} <= winner; out_data <= data_winner; out_valid <= 1; state <= HOLD.
REQ-016 IDLE, req = 0: all outputs hold, state stays IDLE.
REQ-017 Latency: req sampled at edge N -> out_valid=1 and out_data valid after edge N (1 cycle).
REQ-018 HOLD, out_ready=0: s1, s0, out_data, out_valid SHALL stay stable; changes on req or data_i are ignored.
REQ-019 HOLD, out_ready=1 at edge: ack[grantee] <= 1 for exactly one cycle; ptr <= grantee; xfer_count <= xfer_count+1.
REQ-020 On acceptance, re-arbitration SHALL occur at the same edge over req with grantee bit masked; if a requester remains, load it per REQ-015 and stay in HOLD (back-to-back, one word per cycle); else out_valid <= 0, state <= IDLE.
REQ-021 The masked grantee becomes eligible again from the next edge; with all four requesting continuously, grant order is 0,1,2,3,0,... .
REQ-022 A requester dropping req while it is the grantee SHALL NOT cancel the grant; word already captured is delivered.
REQ-023 {s1,s0} SHALL only change at a load edge (REQ-015/REQ-020), never while holding.
REQ-024 ack SHALL be all zero in every cycle without an acceptance; at most one bit set.
REQ-025 busy SHALL equal out_valid.

Reset
REQ-026 reset=1 SHALL asynchronously force: state=IDLE, out_valid=0, out_data=0, s1=s0=0, ack=0, busy=0, xfer_count=0, ptr=3 (requester 0 wins first).
REQ-027 reset asserted in HOLD SHALL discard the held word with no ack pulse and no count increment.
REQ-028 First arbitration SHALL occur on the first rising edge with reset=0.

Verification
REQ-029 After reset, req=4'b1111, data_i=0xA0+i, out_ready=1 held -> grants 0,1,2,3,0 on consecutive cycles, out_data 0xA0,0xA1,0xA2,0xA3,0xA0, ack 0001,0010,0100,1000,0001, xfer_count 5.
REQ-030 req=4'b0100, out_ready=0 for 5 cycles, data2 changed mid-hold -> out_valid=1, {s1,s0}=2'b10, out_data unchanged from capture, ack=0; then out_ready=1 one cycle -> ack=4'b0100, out_valid=0 next cycle.
REQ-031 ptr=1 (last accepted 1), req=4'b0011 -> requester 0 wins (search 2,3,0,1); next acceptance with req=4'b0011 -> requester 1 wins.
REQ-032 Grantee 3 drops req in HOLD, out_ready=1 two cycles later -> word delivered, ack=4'b1000, xfer_count+1.
REQ-033 reset pulsed mid-HOLD (between edges) -> out_valid, s1, s0, out_data, xfer_count 0 immediately, no ack; after release with req=4'b1000 -> requester 3 granted.
REQ-034 xfer_count preset to 0xFFFF via 65535 accepts, one more accept -> 0x0000.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// Four-requester round-robin arbiter feeding a registered 4-to-1 data mux.
// A granted word is held stable until accepted; acceptance re-arbitrates at the same edge.
module mux4_rr_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [WIDTH-1:0] data3,
  output logic             s1,
  output logic             s0,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       ack,
  output logic             busy,
  output logic [15:0]      xfer_count
);

  typedef enum logic {StIdle, StHold} state_e;

  state_e           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [3:0]       ack_q, ack_d;
  logic [15:0]      cnt_q, cnt_d;

  logic             accept;
  logic             load;
  logic [1:0]       arb_base;
  logic [3:0]       arb_req;
  logic [1:0]       win;
  logic             win_found;
  logic [WIDTH-1:0] win_data;

  assign accept = (state_q == StHold) && out_ready;

  // On acceptance the search starts after the grantee and excludes it for this edge only.
  always_comb begin
    arb_base  = accept ? sel_q : ptr_q;
    arb_req   = accept ? (req & ~(4'b0001 << sel_q)) : req;
    win       = arb_base;
    win_found = 1'b0;
    for (int unsigned k = 1; k <= 4; k++) begin
      logic [1:0] idx;
      idx = arb_base + 2'(k);
      if (!win_found && arb_req[idx]) begin
        win_found = 1'b1;
        win       = idx;
      end
    end
  end

  always_comb begin
    win_data = data0;
    unique case (win)
      2'd0: win_data = data0;
      2'd1: win_data = data1;
      2'd2: win_data = data2;
      2'd3: win_data = data3;
      default: win_data = data0;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd3;
      data_q  <= '0;
      ack_q   <= 4'd0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (win_found) state_d = StHold;
      StHold:  if (accept && !win_found) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    load   = ((state_q == StIdle) || accept) && win_found;
    sel_d  = load ? win : sel_q;
    data_d = load ? win_data : data_q;
    ptr_d  = accept ? sel_q : ptr_q;
    ack_d  = accept ? (4'b0001 << sel_q) : 4'b0000;
    cnt_d  = cnt_q + {15'd0, accept};
  end

  // Outputs
  always_comb begin
    s1         = sel_q[1];
    s0         = sel_q[0];
    out_data   = data_q;
    out_valid  = (state_q == StHold);
    busy       = (state_q == StHold);
    ack        = ack_q;
    xfer_count = cnt_q;
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: fairness, hold stability, pointer start, reset and wrap.
module tb_mux4_rr_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] data0, data1, data2, data3;
  logic        s1, s0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  ack;
  logic        busy;
  logic [15:0] xfer_count;

  int vectors;
  int errors;

  mux4_rr_arbiter #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .data0     (data0),
    .data1     (data1),
    .data2     (data2),
    .data3     (data3),
    .s1        (s1),
    .s0        (s0),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ack       (ack),
    .busy      (busy),
    .xfer_count(xfer_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full output snapshot: valid, {s1,s0}, data, ack, count; busy must track valid.
  task automatic chk_all(input string tag, input logic v, input logic [1:0] sel,
                         input logic [31:0] d, input logic [3:0] a, input logic [15:0] c);
    chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
    chk({tag, ".busy"},  {31'd0, busy},      {31'd0, v});
    chk({tag, ".sel"},   {30'd0, s1, s0},    {30'd0, sel});
    chk({tag, ".data"},  out_data,           d);
    chk({tag, ".ack"},   {28'd0, ack},       {28'd0, a});
    chk({tag, ".count"}, {16'd0, xfer_count}, {16'd0, c});
  endtask

  initial begin
    vectors   = 0;
    errors    = 0;
    reset     = 1'b1;
    req       = 4'b0000;
    out_ready = 1'b0;
    data0     = 32'hA0;
    data1     = 32'hA1;
    data2     = 32'hA2;
    data3     = 32'hA3;
    #2;
    chk_all("reset", 1'b0, 2'd0, 32'h0, 4'b0000, 16'd0);
    #5 reset = 1'b0;

    // IDLE with no requests holds everything
    tick();
    chk_all("idle_noreq", 1'b0, 2'd0, 32'h0, 4'b0000, 16'd0);

    // All four requesting, consumer always ready: 0,1,2,3,0
    req       = 4'b1111;
    out_ready = 1'b1;
    tick(); chk_all("rr0", 1'b1, 2'd0, 32'hA0, 4'b0000, 16'd0);
    tick(); chk_all("rr1", 1'b1, 2'd1, 32'hA1, 4'b0001, 16'd1);
    tick(); chk_all("rr2", 1'b1, 2'd2, 32'hA2, 4'b0010, 16'd2);
    tick(); chk_all("rr3", 1'b1, 2'd3, 32'hA3, 4'b0100, 16'd3);
    tick(); chk_all("rr4", 1'b1, 2'd0, 32'hA0, 4'b1000, 16'd4);
    req = 4'b0000;
    tick(); chk_all("rr_drain", 1'b0, 2'd0, 32'hA0, 4'b0001, 16'd5);

    // Hold stability: requester 2, consumer stalled, data and req change under it
    out_ready = 1'b0;
    req       = 4'b0100;
    data2     = 32'h55;
    tick(); chk_all("hold_load", 1'b1, 2'd2, 32'h55, 4'b0000, 16'd5);
    data2 = 32'h66;
    req   = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      tick(); chk_all("hold_stall", 1'b1, 2'd2, 32'h55, 4'b0000, 16'd5);
    end
    out_ready = 1'b1;
    tick(); chk_all("hold_accept", 1'b0, 2'd2, 32'h55, 4'b0100, 16'd6);
    tick(); chk_all("ack_pulse", 1'b0, 2'd2, 32'h55, 4'b0000, 16'd6);

    // Bring ptr to 1, then req 0011 must pick 0 first, then 1
    req = 4'b0010;
    tick(); chk_all("p1_load", 1'b1, 2'd1, 32'hA1, 4'b0000, 16'd6);
    req = 4'b0000;
    tick(); chk_all("p1_acc", 1'b0, 2'd1, 32'hA1, 4'b0010, 16'd7);
    req       = 4'b0011;
    out_ready = 1'b0;
    tick(); chk_all("ptr1_win0", 1'b1, 2'd0, 32'hA0, 4'b0000, 16'd7);
    out_ready = 1'b1;
    tick(); chk_all("ptr0_win1", 1'b1, 2'd1, 32'hA1, 4'b0001, 16'd8);
    req = 4'b0000;
    tick(); chk_all("ptr_drain", 1'b0, 2'd1, 32'hA1, 4'b0010, 16'd9);

    // Grantee 3 drops req while held; word still delivered
    req       = 4'b1000;
    out_ready = 1'b0;
    tick(); chk_all("drop_load", 1'b1, 2'd3, 32'hA3, 4'b0000, 16'd9);
    req = 4'b0000;
    tick(); chk_all("drop_hold", 1'b1, 2'd3, 32'hA3, 4'b0000, 16'd9);
    out_ready = 1'b1;
    tick(); chk_all("drop_deliver", 1'b0, 2'd3, 32'hA3, 4'b1000, 16'd10);

    // Async reset mid-HOLD discards the word; ptr returns to 3
    out_ready = 1'b0;
    req       = 4'b0100;
    tick(); chk_all("rst_load", 1'b1, 2'd2, 32'h66, 4'b0000, 16'd10);
    #3 reset = 1'b1;
    #1 chk_all("rst_async", 1'b0, 2'd0, 32'h0, 4'b0000, 16'd0);
    req = 4'b1000;
    #1 reset = 1'b0;
    tick(); chk_all("rst_after", 1'b1, 2'd3, 32'hA3, 4'b0000, 16'd0);
    out_ready = 1'b1;
    req       = 4'b0000;
    tick(); chk_all("rst_acc", 1'b0, 2'd3, 32'hA3, 4'b1000, 16'd1);

    // Counter wrap: back-to-back accepts up to 0xFFFF, then one more
    req = 4'b1111;
    tick();
    chk("wrap_start", {16'd0, xfer_count}, 32'd1);
    repeat (65534) @(posedge clk);
    #1 chk("wrap_ffff", {16'd0, xfer_count}, 32'hFFFF);
    tick();
    chk("wrap_zero", {16'd0, xfer_count}, 32'h0);
    chk("wrap_valid", {31'd0, out_valid}, 32'd1);
    req = 4'b0000;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
